// File: rtl/peripheral_bridge_ahb2apb.sv
// rtl/peripheral_bridge_ahb2apb.sv - AHB3-Lite slave to APB4 master bridge, one transfer outstanding
module peripheral_bridge_ahb2apb #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = HDATA_SIZE
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int PSTRB_W = PDATA_SIZE / 8;
  localparam logic [PSTRB_W-1:0] STRB_BYTE = PSTRB_W'(1);
  localparam logic [PSTRB_W-1:0] STRB_HALF = PSTRB_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERROR
  } state_t;

  state_t state;

  logic               accept;
  logic [PSTRB_W-1:0] strb_next;
  logic               unused_inputs;

  assign accept = (state == ST_IDLE) && HSEL && HREADY && HTRANS[1];

  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0],
                           HADDR[HADDR_SIZE-1:PADDR_SIZE]};

  // The master holds HWDATA while HREADYOUT is low, so it can feed PWDATA directly.
  assign PWDATA = PSEL ? PDATA_SIZE'(HWDATA) : '0;

  always_comb begin
    strb_next = '0;
    if (HWRITE) begin
      case (HSIZE)
        3'd0:    strb_next = STRB_BYTE << HADDR[1:0];
        3'd1:    strb_next = STRB_HALF << {HADDR[1], 1'b0};
        default: strb_next = '1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      PADDR     <= '0;
      PPROT     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (HSIZE > 3'd2)) begin
            state     <= ST_ERROR;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (accept) begin
            state     <= ST_SETUP;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= HWRITE;
            PSTRB     <= strb_next;
            PADDR     <= HADDR[PADDR_SIZE-1:0];
            PPROT     <= {~HPROT[0], 1'b1, HPROT[1]};
          end else begin
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PSTRB   <= '0;
            if (PSLVERR) begin
              state <= ST_ERROR;
              HRESP <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!PWRITE) HRDATA <= HDATA_SIZE'(PRDATA);
            end
          end
        end
        ST_ERROR: begin
          // Second half of the two-cycle ERROR response.
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bridge_ahb2apb.sv
// tb/tb_peripheral_bridge_ahb2apb.sv - directed table-driven bench for the AHB-to-APB bridge
module tb_peripheral_bridge_ahb2apb;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic [2:0]  PPROT;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  peripheral_bridge_ahb2apb dut (
    .CLK(CLK), .RSTN(RSTN),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        slverr;
    logic [3:0]  prot;
    logic [3:0]  e_strb;
    logic [11:0] e_paddr;
    logic [2:0]  e_pprot;
    logic [31:0] e_hrdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " hreadyout"}, 32'(HREADYOUT), 32'd1);
    chk({tag, " hresp"},     32'(HRESP),     32'd0);
    chk({tag, " hrdata"},    HRDATA,         32'd0);
    chk({tag, " psel"},      32'(PSEL),      32'd0);
    chk({tag, " penable"},   32'(PENABLE),   32'd0);
    chk({tag, " pwrite"},    32'(PWRITE),    32'd0);
    chk({tag, " pstrb"},     32'(PSTRB),     32'd0);
    chk({tag, " paddr"},     32'(PADDR),     32'd0);
    chk({tag, " pwdata"},    PWDATA,         32'd0);
    chk({tag, " pprot"},     32'(PPROT),     32'd0);
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'd0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0; HPROT = 4'd0;
  endtask

  task automatic drive_addr(input vec_t v, input logic [1:0] trans);
    HSEL = 1'b1; HTRANS = trans; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size; HPROT = v.prot;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    @(negedge CLK);
    drive_addr(v, 2'd2);
    #1 chk({t, " addr hreadyout"}, 32'(HREADYOUT), 32'd1);
    @(negedge CLK);
    bus_idle();
    HWDATA = v.wdata;
    #1;
    if (v.size > 3'd2) begin
      chk({t, " err1 hreadyout"}, 32'(HREADYOUT), 32'd0);
      chk({t, " err1 hresp"},     32'(HRESP),     32'd1);
      chk({t, " err1 psel"},      32'(PSEL),      32'd0);
      @(negedge CLK); #1;
      chk({t, " err2 hreadyout"}, 32'(HREADYOUT), 32'd1);
      chk({t, " err2 hresp"},     32'(HRESP),     32'd1);
      chk({t, " err2 psel"},      32'(PSEL),      32'd0);
    end else begin
      chk({t, " setup psel"},      32'(PSEL),      32'd1);
      chk({t, " setup penable"},   32'(PENABLE),   32'd0);
      chk({t, " setup hreadyout"}, 32'(HREADYOUT), 32'd0);
      chk({t, " setup paddr"},     32'(PADDR),     32'(v.e_paddr));
      chk({t, " setup pstrb"},     32'(PSTRB),     32'(v.e_strb));
      chk({t, " setup pwrite"},    32'(PWRITE),    32'(v.wr));
      chk({t, " setup pprot"},     32'(PPROT),     32'(v.e_pprot));
      chk({t, " setup pwdata"},    PWDATA,         v.wdata);
      for (int w = 0; w <= v.waits; w++) begin
        @(negedge CLK);
        PREADY = (w == v.waits); PRDATA = v.rdata; PSLVERR = v.slverr;
        #1;
        chk({t, " access psel"},      32'(PSEL),      32'd1);
        chk({t, " access penable"},   32'(PENABLE),   32'd1);
        chk({t, " access hreadyout"}, 32'(HREADYOUT), 32'd0);
        chk({t, " access paddr"},     32'(PADDR),     32'(v.e_paddr));
        chk({t, " access pwrite"},    32'(PWRITE),    32'(v.wr));
      end
      @(negedge CLK);
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      #1;
      if (v.slverr) begin
        chk({t, " err1 hreadyout"}, 32'(HREADYOUT), 32'd0);
        chk({t, " err1 hresp"},     32'(HRESP),     32'd1);
        chk({t, " err1 psel"},      32'(PSEL),      32'd0);
        @(negedge CLK); #1;
        chk({t, " err2 hreadyout"}, 32'(HREADYOUT), 32'd1);
        chk({t, " err2 hresp"},     32'(HRESP),     32'd1);
      end else begin
        chk({t, " done hreadyout"}, 32'(HREADYOUT), 32'd1);
        chk({t, " done hresp"},     32'(HRESP),     32'd0);
        chk({t, " done psel"},      32'(PSEL),      32'd0);
        chk({t, " done pwdata"},    PWDATA,         32'd0);
      end
      chk({t, " hrdata"}, HRDATA, v.e_hrdata);
    end
    @(negedge CLK); #1;
    chk({t, " idle hresp"},     32'(HRESP),     32'd0);
    chk({t, " idle hreadyout"}, 32'(HREADYOUT), 32'd1);
  endtask

  initial begin
    vec_t hw, rd;
    //          wr  size  addr          wdata   rdata         wt err prot   strb     paddr    pprot   hrdata
    vecs[0] = '{1'b1, 3'd2, 32'h0000_0003, 32'h41, 32'h0,        0, 1'b0, 4'b0011, 4'b1111, 12'h003, 3'b011, 32'h0};
    vecs[1] = '{1'b0, 3'd0, 32'h0000_0005, 32'h9,  32'h60,       0, 1'b0, 4'b0010, 4'b0000, 12'h005, 3'b111, 32'h60};
    vecs[2] = '{1'b0, 3'd2, 32'h1234_5ABC, 32'h0,  32'hDEADBEEF, 3, 1'b0, 4'b0001, 4'b0000, 12'hABC, 3'b010, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 3'd0, 32'h0000_0102, 32'hAA, 32'h11,       1, 1'b0, 4'b0000, 4'b0100, 12'h102, 3'b110, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 3'd1, 32'h0000_0007, 32'hBEEF_0000, 32'h0, 0, 1'b0, 4'b0000, 4'b1100, 12'h007, 3'b110, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,  32'h55,       0, 1'b1, 4'b0011, 4'b0000, 12'h010, 3'b011, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 3'd3, 32'h0000_0020, 32'h1,  32'h0,        0, 1'b0, 4'b0011, 4'b0000, 12'h000, 3'b000, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 3'd0, 32'h0000_0003, 32'h7700_0000, 32'h0, 0, 1'b0, 4'b0011, 4'b1000, 12'h003, 3'b011, 32'hDEADBEEF};

    RSTN = 1'b0; HREADY = 1'b1; HBURST = 3'd0; HMASTLOCK = 1'b0; HWDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    bus_idle();
    @(negedge CLK); @(negedge CLK); #1;
    chk_reset_vals("reset");
    @(negedge CLK);
    RSTN = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Halfword write followed by a SEQ read in the completion cycle.
    hw = '{1'b1, 3'd1, 32'h0000_0042, 32'h1234_0000, 32'h0, 0, 1'b0, 4'b0011, 4'b1100, 12'h042, 3'b011, 32'h0};
    rd = '{1'b0, 3'd2, 32'h0000_0048, 32'h0, 32'h77, 0, 1'b0, 4'b0011, 4'b0000, 12'h048, 3'b011, 32'h77};
    @(negedge CLK);
    drive_addr(hw, 2'd2);
    @(negedge CLK);
    bus_idle(); HWDATA = hw.wdata;
    #1 chk("b2b setup1 pstrb", 32'(PSTRB), 32'hC);
    @(negedge CLK);
    PREADY = 1'b1;
    #1 chk("b2b access1 penable", 32'(PENABLE), 32'd1);
    @(negedge CLK);
    PREADY = 1'b0;
    drive_addr(rd, 2'd3);
    #1 chk("b2b done1 hreadyout", 32'(HREADYOUT), 32'd1);
    chk("b2b done1 hresp", 32'(HRESP), 32'd0);
    @(negedge CLK);
    bus_idle();
    #1 chk("b2b setup2 psel", 32'(PSEL), 32'd1);
    chk("b2b setup2 penable", 32'(PENABLE), 32'd0);
    chk("b2b setup2 paddr", 32'(PADDR), 32'h048);
    chk("b2b setup2 pstrb", 32'(PSTRB), 32'd0);
    chk("b2b setup2 pwrite", 32'(PWRITE), 32'd0);
    @(negedge CLK);
    PREADY = 1'b1; PRDATA = 32'h77;
    @(negedge CLK);
    PREADY = 1'b0; PRDATA = '0;
    #1 chk("b2b done2 hreadyout", 32'(HREADYOUT), 32'd1);
    chk("b2b done2 hrdata", HRDATA, 32'h77);

    // Reset asserted while the bridge waits in ACCESS.
    @(negedge CLK);
    drive_addr(rd, 2'd2);
    @(negedge CLK);
    bus_idle(); HWDATA = 32'h5A5A_5A5A;
    @(negedge CLK);
    #1 chk("rst pre penable", 32'(PENABLE), 32'd1);
    RSTN = 1'b0;
    #1 chk_reset_vals("rst mid");
    @(negedge CLK);
    PREADY = 1'b1;
    #1 chk("rst held hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst held psel", 32'(PSEL), 32'd0);
    @(negedge CLK);
    PREADY = 1'b0; RSTN = 1'b1;
    run_vec(8, '{1'b0, 3'd2, 32'h0000_0ABC, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 4'b0010, 4'b0000, 12'hABC, 3'b111, 32'hCAFE_F00D});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
